// File: rtl/usr_shift_ctrl.sv
// Command sequencer for a universal shift register: takes LOAD/SHL/SHR/ROTL
// commands over valid/ready and drives mode select, serial and parallel data.
module usr_shift_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [CNT_W-1:0] i_cmd_cnt,
  input  logic [WIDTH-1:0] i_cmd_data,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_q,
  output logic [1:0]       o_sel,
  output logic             o_sdi,
  output logic [WIDTH-1:0] o_par,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned K_W   = CNT_W + 1;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SHR   = 2'b10;
  localparam logic [1:0] OP_ROTL  = 2'b11;
  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_UP   = 2'b01;
  localparam logic [1:0] SEL_DOWN = 2'b10;
  localparam logic [1:0] SEL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       sel_q;
  logic             sdi_q;
  logic             rot_q;
  logic [WIDTH-1:0] par_q;
  logic             busy_q;
  logic             done_q;

  logic             accept_c;
  logic [K_W-1:0]   k_next_c;
  logic             last_c;
  logic             sdi_next_c;
  logic             unused_c;

  // Next bit index; a zero count makes the first (bookkeeping) cycle the last one.
  assign accept_c   = i_cmd_valid & o_cmd_ready;
  assign k_next_c   = K_W'(idx_q) + K_W'(1);
  assign last_c     = (k_next_c >= K_W'(cnt_q));
  assign sdi_next_c = (k_next_c < K_W'(WIDTH)) ? data_q[k_next_c[IDX_W-1:0]] : 1'b0;
  assign unused_c   = ^i_q[WIDTH-2:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      sel_q   <= SEL_HOLD;
      sdi_q   <= 1'b0;
      rot_q   <= 1'b0;
      par_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_c) begin
            data_q <= i_cmd_data;
            cnt_q  <= i_cmd_cnt;
            idx_q  <= '0;
            busy_q <= 1'b1;
            if (i_cmd_op == OP_LOAD) begin
              state_q <= S_LOAD;
              sel_q   <= SEL_LOAD;
              par_q   <= i_cmd_data;
            end else begin
              state_q <= S_SHIFT;
              if (i_cmd_cnt == '0) begin
                sel_q <= SEL_HOLD;
                sdi_q <= 1'b0;
                rot_q <= 1'b0;
              end else begin
                sel_q <= (i_cmd_op == OP_SHR) ? SEL_DOWN : SEL_UP;
                sdi_q <= (i_cmd_op == OP_ROTL) ? 1'b0 : i_cmd_data[0];
                rot_q <= (i_cmd_op == OP_ROTL);
              end
            end
          end
        end
        S_LOAD: begin
          state_q <= S_IDLE;
          sel_q   <= SEL_HOLD;
          busy_q  <= 1'b0;
          done_q  <= ~i_abort;
        end
        S_SHIFT: begin
          if (i_abort || last_c) begin
            state_q <= S_IDLE;
            sel_q   <= SEL_HOLD;
            sdi_q   <= 1'b0;
            rot_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= ~i_abort;
          end else begin
            idx_q <= idx_q + CNT_W'(1);
            sdi_q <= sdi_next_c;
          end
        end
        default: begin
          state_q <= S_IDLE;
          sel_q   <= SEL_HOLD;
          sdi_q   <= 1'b0;
          rot_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Rotate feeds the register's own MSB back without an extra cycle of latency.
  assign o_sdi       = rot_q ? i_q[WIDTH-1] : sdi_q;
  assign o_cmd_ready = ~busy_q & ~i_rst;
  assign o_sel       = sel_q;
  assign o_par       = par_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule
